// File: rtl/i2c_pkg.sv
// Shared types and constants for the 16-byte I2C EEPROM responder.
package i2c_pkg;

  // Protocol FSM states.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CTRL      = 4'd1,
    ST_ACK_CTRL  = 4'd2,
    ST_WADDR     = 4'd3,
    ST_ACK_WADDR = 4'd4,
    ST_WDATA     = 4'd5,
    ST_ACK_WDATA = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RACK      = 4'd8
  } state_e;

  localparam logic [6:0] DEV_ADDR = 7'h50;
  localparam logic [7:0] CTRL_WR  = {DEV_ADDR, 1'b0};
  localparam logic [7:0] CTRL_RD  = {DEV_ADDR, 1'b1};

  localparam int unsigned MEM_DEPTH = 16;
  localparam int unsigned PTR_W     = 4;

  // Bit counter values: 7 = eighth bit being sampled, 8 = all eight data
  // bits seen, 9 = master ACK seen during the read-acknowledge slot.
  localparam logic [3:0] BIT_LAST  = 4'd7;
  localparam logic [3:0] BIT_DONE  = 4'd8;
  localparam logic [3:0] BIT_MACK  = 4'd9;

  // True when a received control byte addresses this target.
  function automatic logic ctrl_match(input logic [7:0] ctrl,
                                      input logic [6:0] dev);
    return ctrl[7:1] == dev;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into the system clock domain and produces
// single-cycle SCL edge, START and STOP event pulses.
module i2c_bus_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_o
);

  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;
  logic scl_rise_q, scl_fall_q, start_q, stop_q, sda_q;

  // Two-flop synchronizers plus one history stage; idle bus level is high,
  // so resetting to 1 avoids spurious edges when reset releases.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  // Registered event detection; SDA sample is aligned with the SCL pulses.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      sda_q      <= 1'b1;
    end else begin
      scl_rise_q <= scl_sync_q & ~scl_prev_q;
      scl_fall_q <= ~scl_sync_q & scl_prev_q;
      start_q    <= scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
      stop_q     <= scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
      sda_q      <= sda_sync_q;
    end
  end

  assign scl_rise_o = scl_rise_q;
  assign scl_fall_o = scl_fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign sda_o      = sda_q;

endmodule

// File: rtl/i2c_eeprom_responder.sv
// I2C target emulating a 16-byte 24-series EEPROM with a local read port
// and a write strobe for display/debug. SCL is only ever observed.
module i2c_eeprom_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR_P = i2c_pkg::DEV_ADDR
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       i2c_sclk_i,
  inout  wire        i2c_sdat_io,
  input  logic [3:0] rd_addr_i,
  output logic [7:0] rd_data_o,
  output logic       wr_strobe_o,
  output logic [3:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       busy_o
);

  logic scl_rise, scl_fall, bus_start, bus_stop, sda_bit;

  i2c_bus_sync u_sync (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .scl_i      (i2c_sclk_i),
    .sda_i      (i2c_sdat_io),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (bus_start),
    .stop_o     (bus_stop),
    .sda_o      (sda_bit)
  );

  state_e             state_q, state_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [6:0]         shift_q, shift_d;
  logic [6:0]         tx_q, tx_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               sda_low_q, sda_low_d;
  logic               busy_q, busy_d;
  logic               rw_q, rw_d;
  logic               wr_strobe_q, wr_strobe_d;
  logic [3:0]         wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic [7:0]         rd_data_q;
  logic [7:0]         mem_q [MEM_DEPTH];
  logic               mem_we;

  logic [7:0] rx_byte;
  logic [7:0] rd_byte;
  logic       last_bit;

  // Byte being completed by the current SCL rise, and the byte to transmit.
  assign rx_byte  = {shift_q, sda_bit};
  assign rd_byte  = mem_q[ptr_q];
  assign last_bit = (bit_cnt_q == BIT_LAST);

  // Next-state and output decode; START/STOP override any bit activity.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    sda_low_d   = sda_low_q;
    busy_d      = busy_q;
    rw_d        = rw_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;

    if (bus_start) begin
      state_d   = ST_CTRL;
      bit_cnt_d = '0;
      sda_low_d = 1'b0;
    end else if (bus_stop) begin
      state_d   = ST_IDLE;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sda_low_d = 1'b0;
        end

        ST_CTRL: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              bit_cnt_d = '0;
              if (ctrl_match(rx_byte, DEV_ADDR_P)) begin
                state_d = ST_ACK_CTRL;
                rw_d    = rx_byte[0];
                busy_d  = 1'b1;
              end else begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
              end
            end
          end
        end

        // In the ACK states SDA is released on entry; the first SCL fall
        // pulls it low and the second ends the acknowledge slot.
        ST_ACK_CTRL: begin
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else if (rw_q) begin
              state_d   = ST_RDATA;
              tx_d      = rd_byte[6:0];
              sda_low_d = ~rd_byte[7];
              bit_cnt_d = '0;
            end else begin
              state_d   = ST_WADDR;
              sda_low_d = 1'b0;
            end
          end
        end

        ST_WADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              bit_cnt_d = '0;
              ptr_d     = rx_byte[7:4];
              state_d   = ST_ACK_WADDR;
            end
          end
        end

        ST_ACK_WADDR: begin
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else begin
              state_d   = ST_WDATA;
              sda_low_d = 1'b0;
            end
          end
        end

        ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              bit_cnt_d   = '0;
              mem_we      = 1'b1;
              wr_strobe_d = 1'b1;
              wr_addr_d   = ptr_q;
              wr_data_d   = rx_byte;
              ptr_d       = ptr_q + 1'b1;
              state_d     = ST_ACK_WDATA;
            end
          end
        end

        ST_ACK_WDATA: begin
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else begin
              state_d   = ST_WDATA;
              sda_low_d = 1'b0;
            end
          end
        end

        // Bit 7 is already on the bus at entry; each later fall shifts the
        // next bit out until all eight have been clocked.
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == BIT_DONE) begin
              sda_low_d = 1'b0;
              ptr_d     = ptr_q + 1'b1;
              state_d   = ST_RACK;
            end else begin
              sda_low_d = ~tx_q[6];
              tx_d      = {tx_q[5:0], 1'b0};
            end
          end
        end

        ST_RACK: begin
          if (scl_rise) begin
            if (!sda_bit) begin
              bit_cnt_d = BIT_MACK;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end else if (scl_fall && bit_cnt_q == BIT_MACK) begin
            state_d   = ST_RDATA;
            tx_d      = rd_byte[6:0];
            sda_low_d = ~rd_byte[7];
            bit_cnt_d = '0;
          end
        end

        default: begin
          state_d   = ST_IDLE;
          sda_low_d = 1'b0;
          busy_d    = 1'b0;
        end
      endcase
    end
  end

  // Protocol state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      ptr_q       <= '0;
      sda_low_q   <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      sda_low_q   <= sda_low_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Memory array and registered local read port.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (mem_we) begin
        mem_q[ptr_q] <= rx_byte;
      end
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign i2c_sdat_io = sda_low_q ? 1'b0 : 1'bz;
  assign rd_data_o   = rd_data_q;
  assign wr_strobe_o = wr_strobe_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_i2c_eeprom_responder.sv
// Self-checking bench: bit-banged I2C master plus a transaction-level
// EEPROM model (array + pointer) for the responder.
module tb_i2c_eeprom_responder;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       scl;
  logic       sda_m;
  wire        sda;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  pullup (sda);
  assign sda = sda_m ? 1'bz : 1'b0;

  i2c_eeprom_responder dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .i2c_sclk_i  (scl),
    .i2c_sdat_io (sda),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .wr_strobe_o (wr_strobe),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mdl_mem [16];
  logic [3:0] mdl_ptr;
  int         mdl_strobes;
  logic [7:0] wbuf [16];

  int         strobe_cnt  = 0;
  int         wide_cnt    = 0;
  logic       prev_strobe = 1'b0;
  logic [3:0] last_wa     = '0;
  logic [7:0] last_wd     = '0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Strobe monitor: captures the write port on each pulse and counts pulses
  // that last longer than one cycle.
  always @(posedge clk) begin
    #1;
    if (wr_strobe) begin
      strobe_cnt++;
      last_wa = wr_addr;
      last_wd = wr_data;
      if (prev_strobe) wide_cnt++;
    end
    prev_strobe = wr_strobe;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_bit(input logic b, output logic r);
    tick(Q); sda_m = b;
    tick(Q); scl = 1'b1;
    tick(Q); r = sda;
    tick(Q); scl = 1'b0;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    sda_m = 1'b0; tick(Q);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
    bus_bit(1'b1, r);
    acked = ~r;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      b[i] = r;
    end
    bus_bit(nack, r);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mdl_mem[i] = 8'h00;
    mdl_ptr = 4'h0;
  endtask

  task automatic check_mem_port();
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      tick(1);
      check_eq("rd_port", rd_data, mdl_mem[a]);
    end
  endtask

  task automatic do_write(input logic [3:0] wa, input int n);
    logic a;
    int   s0;
    s0 = strobe_cnt;
    bus_start();
    send_byte(i2c_pkg::CTRL_WR, a);
    check_eq("ack_ctrl_wr", a, 1);
    check_eq("busy_addressed", busy, 1);
    send_byte({wa, 4'($urandom)}, a);
    check_eq("ack_waddr", a, 1);
    mdl_ptr = wa;
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], a);
      check_eq("ack_wdata", a, 1);
      check_eq("wr_strobe_count", strobe_cnt - s0, i + 1);
      check_eq("wr_addr", last_wa, mdl_ptr);
      check_eq("wr_data", last_wd, wbuf[i]);
      mdl_mem[mdl_ptr] = wbuf[i];
      mdl_ptr = mdl_ptr + 4'h1;
      mdl_strobes++;
    end
    bus_stop();
    tick(4);
    check_eq("busy_after_stop", busy, 0);
    check_eq("sda_after_stop", sda, 1);
  endtask

  task automatic do_read(input logic set_addr, input logic [3:0] ra,
                         input int n);
    logic       a;
    logic [7:0] b;
    if (set_addr) begin
      bus_start();
      send_byte(i2c_pkg::CTRL_WR, a);
      check_eq("ack_ctrl_wr", a, 1);
      send_byte({ra, 4'($urandom)}, a);
      check_eq("ack_waddr", a, 1);
      mdl_ptr = ra;
    end
    bus_start();
    send_byte(i2c_pkg::CTRL_RD, a);
    check_eq("ack_ctrl_rd", a, 1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, b);
      check_eq("rd_byte", b, mdl_mem[mdl_ptr]);
      mdl_ptr = mdl_ptr + 4'h1;
    end
    check_eq("busy_after_nack", busy, 0);
    bus_stop();
    tick(4);
    check_eq("sda_after_read", sda, 1);
    check_eq("busy_after_read", busy, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a;
    logic       r;
    int         n;
    int         s0;

    reset_i = 1'b1;
    scl     = 1'b1;
    sda_m   = 1'b1;
    rd_addr = 4'h0;
    model_reset();
    mdl_strobes = 0;
    tick(3);
    reset_i = 1'b0;
    tick(2);
    check_eq("rst_sda", sda, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_wr_strobe", wr_strobe, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_wr_data", wr_data, 0);
    check_eq("rst_rd_data", rd_data, 0);

    // Single byte write then local readback.
    wbuf[0] = 8'h5A;
    do_write(4'h3, 1);
    rd_addr = 4'h3;
    tick(1);
    check_eq("rd_port_5a", rd_data, 8'h5A);

    // Random read through repeated START.
    do_read(1'b1, 4'h3, 1);

    // Wrong device address: no ACK, following bytes ignored.
    s0 = strobe_cnt;
    bus_start();
    send_byte(8'hA2, a);
    check_eq("nack_wrong_addr", a, 0);
    check_eq("busy_wrong_addr", busy, 0);
    send_byte(8'h30, a);
    check_eq("ignored_waddr", a, 0);
    send_byte(8'h77, a);
    check_eq("ignored_wdata", a, 0);
    bus_stop();
    tick(4);
    check_eq("no_strobe_wrong_addr", strobe_cnt - s0, 0);
    check_mem_port();

    // Page wrap on write, pointer left at 1, sequential read wrap.
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    do_write(4'hF, 2);
    do_read(1'b0, 4'h0, 1);
    do_read(1'b1, 4'hF, 2);

    // Randomized mix of writes and reads.
    for (int it = 0; it < 12; it++) begin
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
        do_write(4'($urandom), n);
      end else begin
        do_read(1'($urandom_range(0, 1)), 4'($urandom), n);
      end
    end
    check_mem_port();

    // Reset in the middle of a read byte.
    wbuf[0] = 8'h00;
    wbuf[1] = 8'hA5;
    do_write(4'h5, 2);
    rd_addr = 4'h6;
    tick(1);
    check_eq("rd_port_pre_reset", rd_data, 8'hA5);
    bus_start();
    send_byte(i2c_pkg::CTRL_WR, a);
    send_byte(8'h50, a);
    bus_start();
    send_byte(i2c_pkg::CTRL_RD, a);
    check_eq("ack_ctrl_rd_pre_reset", a, 1);
    for (int i = 0; i < 3; i++) bus_bit(1'b1, r);
    tick(Q);
    check_eq("sda_driven_mid_byte", sda, 0);
    check_eq("busy_mid_byte", busy, 1);
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_mid_sda", sda, 1);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_rd_data", rd_data, 0);
    sda_m = 1'b1;
    tick(2);
    scl = 1'b1;
    tick(2);
    reset_i = 1'b0;
    tick(2);
    model_reset();
    check_mem_port();

    // Fresh transfers after reset.
    wbuf[0] = 8'h3C;
    do_write(4'h2, 1);
    do_read(1'b1, 4'h2, 1);
    do_read(1'b0, 4'h0, 1);

    check_eq("strobe_width", wide_cnt, 0);
    check_eq("strobe_total", strobe_cnt, mdl_strobes);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
